// File: rtl/mascota_necesidades_multi.sv
// Pet-state engine: N saturating need levels with prescaled decay, edge-triggered refills and a VIVO/TEST/CRITICO/MUERTO FSM.
// The TEST mode (hold counter, fast divider) is built only when MASCOTA_TEST_MODE_EN is defined.

module mascota_canal #(
    parameter int LVL_W     = 3,
    parameter int LVL_MAX   = 5,
    parameter int STEP      = 2,
    parameter int LVL_ALARM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             refill,
    output logic [LVL_W-1:0] lvl_nxt,
    output logic [LVL_W-1:0] lvl,
    output logic             alarm
);
    logic [LVL_W:0]   ext_dec;
    logic [LVL_W:0]   ext_add;
    logic [LVL_W-1:0] lvl_d, lvl_q;
    logic             alarm_d, alarm_q;

    // Decrement first, then refill; the extra bit keeps the sum from wrapping before the clamp.
    always_comb begin
        ext_dec = {1'b0, lvl_q};
        if (tick && ext_dec != '0) begin
            ext_dec = ext_dec - 1'b1;
        end
        ext_add = ext_dec;
        if (refill) begin
            ext_add = ext_dec + (LVL_W+1)'(STEP);
        end
        if (ext_add > (LVL_W+1)'(LVL_MAX)) begin
            ext_add = (LVL_W+1)'(LVL_MAX);
        end
        lvl_d   = ext_add[LVL_W-1:0];
        alarm_d = (lvl_d <= LVL_W'(LVL_ALARM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= LVL_W'(LVL_MAX);
            alarm_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            alarm_q <= alarm_d;
        end
    end

    assign lvl_nxt = lvl_d;
    assign lvl     = lvl_q;
    assign alarm   = alarm_q;
endmodule

module mascota_necesidades_multi #(
    parameter int N_NEEDS    = 3,
    parameter int LVL_W      = 3,
    parameter int LVL_MAX    = 5,
    parameter int STEP       = 2,
    parameter int LVL_ALARM  = 1,
    parameter int TICK_DIV   = 50_000_000,
    parameter int TEST_DIV   = 50_000,
    parameter int HOLD_CYC   = 150_000_000,
    parameter int CRIT_TICKS = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_NEEDS-1:0]       btn_need,
    input  logic                     btn_test,
    output logic [N_NEEDS*LVL_W-1:0] nivel,
    output logic [1:0]               estado,
    output logic [N_NEEDS-1:0]       alarma,
    output logic                     tick_o
);
    localparam int DIV_MAX = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
    localparam int PS_W    = $clog2(DIV_MAX + 1);
    localparam int CR_W    = $clog2(CRIT_TICKS + 1);

    typedef enum logic [1:0] {
        VIVO    = 2'b00,
        TEST    = 2'b01,
        CRITICO = 2'b10,
        MUERTO  = 2'b11
    } estado_t;

    estado_t                          state_q, state_d;
    logic [PS_W-1:0]                  cnt_q, cnt_d;
    logic [PS_W-1:0]                  div_m1;
    logic [CR_W-1:0]                  crit_q, crit_d;
    logic [N_NEEDS-1:0]               btn_q, btn_d;
    logic [N_NEEDS-1:0]               refill;
    logic [N_NEEDS-1:0]               zero_nxt;
    logic [N_NEEDS-1:0][LVL_W-1:0]    lvl_nxt;
    logic                             tick;
    logic                             toggle;
    logic                             alive;

    assign alive = (state_q != MUERTO);

`ifdef MASCOTA_TEST_MODE_EN
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              lock_q, lock_d;

    // After a toggle the counter stays parked until btn_test is released.
    always_comb begin
        hold_d = '0;
        lock_d = 1'b0;
        toggle = 1'b0;
        if (btn_test && alive) begin
            lock_d = lock_q;
            if (!lock_q) begin
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    toggle = 1'b1;
                    lock_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            lock_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            lock_q <= lock_d;
        end
    end

    assign div_m1 = (state_q == TEST) ? PS_W'(TEST_DIV - 1) : PS_W'(TICK_DIV - 1);
`else
    localparam int hold_cyc_unused = HOLD_CYC;
    logic test_unused;

    assign test_unused = btn_test;
    assign toggle      = 1'b0;
    assign div_m1      = PS_W'(TICK_DIV - 1);
`endif

    always_comb begin
        tick  = alive && (cnt_q >= div_m1);
        cnt_d = cnt_q;
        if (alive) begin
            cnt_d = (tick || toggle) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        btn_d  = btn_need;
        refill = btn_need & ~btn_q & {N_NEEDS{alive}};
    end

    for (genvar i = 0; i < N_NEEDS; i++) begin : g_ch
        mascota_canal #(
            .LVL_W    (LVL_W),
            .LVL_MAX  (LVL_MAX),
            .STEP     (STEP),
            .LVL_ALARM(LVL_ALARM)
        ) u_ch (
            .clk    (clk),
            .rst_n  (reset),
            .tick   (tick),
            .refill (refill[i]),
            .lvl_nxt(lvl_nxt[i]),
            .lvl    (nivel[i*LVL_W +: LVL_W]),
            .alarm  (alarma[i])
        );
        assign zero_nxt[i] = (lvl_nxt[i] == '0);
    end

    // Transitions look at next-cycle levels so estado moves on the same edge as nivel.
    always_comb begin
        state_d = state_q;
        crit_d  = '0;
        case (state_q)
            VIVO: begin
                if (toggle) begin
                    state_d = TEST;
                end else if (|zero_nxt) begin
                    state_d = CRITICO;
                end
            end
            TEST: begin
                if (toggle) begin
                    state_d = (|zero_nxt) ? CRITICO : VIVO;
                end
            end
            CRITICO: begin
                if (toggle) begin
                    state_d = TEST;
                end else if (!(|zero_nxt)) begin
                    state_d = VIVO;
                end else if (tick) begin
                    if (crit_q == CR_W'(CRIT_TICKS - 1)) begin
                        state_d = MUERTO;
                    end else begin
                        crit_d = crit_q + 1'b1;
                    end
                end else begin
                    crit_d = crit_q;
                end
            end
            default: state_d = MUERTO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= VIVO;
            cnt_q   <= '0;
            crit_q  <= '0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crit_q  <= crit_d;
            btn_q   <= btn_d;
        end
    end

    assign estado = state_q;
    assign tick_o = tick;
endmodule
